// File: rtl/ex_mem_flag_stage_if.sv
// rtl/ex_mem_flag_stage_if.sv - EX-to-MEM pipeline bundle: EX-side inputs and MEM-side registered outputs.
interface ex_mem_flag_stage_if #(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 4
);
  logic                  ex_valid;
  logic [3:0]            ex_op;
  logic [DATA_W-1:0]     ex_alu_out;
  logic                  ex_n;
  logic                  ex_z;
  logic                  ex_v;
  logic [2:0]            ex_cond;
  logic [DATA_W-1:0]     ex_store_data;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  ex_we;

  logic                  mem_valid;
  logic [3:0]            mem_op;
  logic [DATA_W-1:0]     mem_alu_out;
  logic [DATA_W-1:0]     mem_store_data;
  logic [REG_ADDR_W-1:0] mem_rd;
  logic                  mem_we;
  logic                  mem_br_taken;

  modport master (
    output ex_valid, ex_op, ex_alu_out, ex_n, ex_z, ex_v, ex_cond,
           ex_store_data, ex_rd, ex_we,
    input  mem_valid, mem_op, mem_alu_out, mem_store_data, mem_rd,
           mem_we, mem_br_taken
  );

  modport slave (
    input  ex_valid, ex_op, ex_alu_out, ex_n, ex_z, ex_v, ex_cond,
           ex_store_data, ex_rd, ex_we,
    output mem_valid, mem_op, mem_alu_out, mem_store_data, mem_rd,
           mem_we, mem_br_taken
  );
endinterface

// File: rtl/ex_mem_flag_stage.sv
// rtl/ex_mem_flag_stage.sv - EX/MEM pipeline register with N/Z/V condition codes and branch resolution.
module ex_mem_flag_stage #(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                flush,
  ex_mem_flag_stage_if.slave  bus,
  output logic                flag_n,
  output logic                flag_z,
  output logic                flag_v
);

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_NAND = 4'h2;
  localparam logic [3:0] OP_XOR  = 4'h3;
  localparam logic [3:0] OP_INC  = 4'h4;
  localparam logic [3:0] OP_B    = 4'hC;
  localparam logic [3:0] OP_NOP  = 4'hF;

  localparam logic [DATA_W-1:0]     ZERO_DATA = '0;
  localparam logic [REG_ADDR_W-1:0] ZERO_RD   = '0;

  logic capture;
  logic flag_op;
  logic cond_true;
  logic br_taken_next;

  // A real instruction moves into MEM only when not stalled and not flushed.
  always_comb begin
    capture = !stall && !flush && bus.ex_valid;
  end

  always_comb begin
    flag_op = 1'b0;
    case (bus.ex_op)
      OP_ADD, OP_SUB, OP_NAND, OP_XOR, OP_INC: flag_op = 1'b1;
      default:                                 flag_op = 1'b0;
    endcase
  end

  // Branches test the flags already in the register, i.e. the previous producer's result.
  always_comb begin
    cond_true = 1'b0;
    case (bus.ex_cond)
      3'b000:  cond_true = !flag_z;
      3'b001:  cond_true = flag_z;
      3'b010:  cond_true = !flag_z && !flag_n;
      3'b011:  cond_true = flag_n;
      3'b100:  cond_true = !flag_n || flag_z;
      3'b101:  cond_true = flag_n || flag_z;
      3'b110:  cond_true = flag_v;
      default: cond_true = 1'b1;
    endcase
  end

  always_comb begin
    br_taken_next = (bus.ex_op == OP_B) && cond_true;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.mem_valid      <= 1'b0;
      bus.mem_op         <= OP_NOP;
      bus.mem_alu_out    <= ZERO_DATA;
      bus.mem_store_data <= ZERO_DATA;
      bus.mem_rd         <= ZERO_RD;
      bus.mem_we         <= 1'b0;
      bus.mem_br_taken   <= 1'b0;
    end else if (!stall) begin
      if (capture) begin
        bus.mem_valid      <= 1'b1;
        bus.mem_op         <= bus.ex_op;
        bus.mem_alu_out    <= bus.ex_alu_out;
        bus.mem_store_data <= bus.ex_store_data;
        bus.mem_rd         <= bus.ex_rd;
        bus.mem_we         <= bus.ex_we;
        bus.mem_br_taken   <= br_taken_next;
      end else begin
        bus.mem_valid      <= 1'b0;
        bus.mem_op         <= OP_NOP;
        bus.mem_alu_out    <= ZERO_DATA;
        bus.mem_store_data <= ZERO_DATA;
        bus.mem_rd         <= ZERO_RD;
        bus.mem_we         <= 1'b0;
        bus.mem_br_taken   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_n <= 1'b0;
      flag_z <= 1'b0;
      flag_v <= 1'b0;
    end else if (capture && flag_op) begin
      flag_n <= bus.ex_n;
      flag_z <= bus.ex_z;
      flag_v <= bus.ex_v;
    end
  end

endmodule
